// File: rtl/crc32_stream_engine.sv
// rtl/crc32_stream_engine.sv - multi-byte-per-beat Ethernet CRC-32 engine with frame length and residue check
module crc32_stream_engine #(
    parameter int DATA_BYTES = 8,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic                    in_eof,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    output logic                    crc_valid,
    output logic [31:0]             crc_out,
    output logic                    crc_ok,
    output logic [LEN_W-1:0]        frame_len,
    output logic                    sync_err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    state_t          state;
    logic [31:0]     crc_reg;
    logic [LEN_W-1:0] len_reg;

    logic [DATA_BYTES-1:0] keep_eff;
    logic [31:0]           crc_next;
    logic [LEN_W:0]        len_sum;
    logic [LEN_W-1:0]      len_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // A sof beat always reseeds, even when it aborts a partial frame.
    always_comb begin
        keep_eff = in_eof ? in_keep : {DATA_BYTES{1'b1}};
        crc_next = (in_sof || state == IDLE) ? CRC_INIT : crc_reg;
        len_sum  = {1'b0, (in_sof ? {LEN_W{1'b0}} : len_reg)};
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (keep_eff[i])
                crc_next = crc_byte(crc_next, in_data[8*i +: 8]);
            len_sum = len_sum + {{LEN_W{1'b0}}, keep_eff[i]};
        end
        len_next = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crc_reg   <= CRC_INIT;
            len_reg   <= '0;
            crc_valid <= 1'b0;
            crc_out   <= '0;
            crc_ok    <= 1'b0;
            frame_len <= '0;
            sync_err  <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid) begin
                if (in_sof || state == ACTIVE) begin
                    if (in_sof && state == ACTIVE)
                        sync_err <= 1'b1;
                    crc_reg <= crc_next;
                    len_reg <= len_next;
                    if (in_eof) begin
                        state     <= IDLE;
                        crc_valid <= 1'b1;
                        crc_out   <= ~crc_next;
                        crc_ok    <= (crc_next == CRC_RESIDUE);
                        frame_len <= len_next;
                    end else begin
                        state <= ACTIVE;
                    end
                end else begin
                    sync_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// tb/tb_crc32_stream_engine.sv - scoreboard bench for crc32_stream_engine at 8 and 1 bytes per beat
module tb_crc32_stream_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        v, sof, eof;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        crc_valid, crc_ok, sync_err;
    logic [31:0] crc_out;
    logic [15:0] frame_len;

    logic        v1, sof1, eof1;
    logic [7:0]  d1;
    logic [0:0]  k1;
    logic        crc_valid1, crc_ok1, sync_err1;
    logic [31:0] crc_out1;
    logic [15:0] frame_len1;

    always #5 clk = ~clk;

    crc32_stream_engine #(.DATA_BYTES(8), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(v), .in_sof(sof), .in_eof(eof),
        .in_data(data), .in_keep(keep), .crc_valid(crc_valid), .crc_out(crc_out),
        .crc_ok(crc_ok), .frame_len(frame_len), .sync_err(sync_err));

    crc32_stream_engine #(.DATA_BYTES(1), .LEN_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_sof(sof1), .in_eof(eof1),
        .in_data(d1), .in_keep(k1), .crc_valid(crc_valid1), .crc_out(crc_out1),
        .crc_ok(crc_ok1), .frame_len(frame_len1), .sync_err(sync_err1));

    typedef struct {
        logic [31:0] crc;
        logic        ok;
        logic [15:0] len;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        int          exp_len;
        bit          crc_known;
        logic [31:0] exp_crc;
    } vec_t;

    exp_t sb[$];
    int total = 0, bad = 0;
    int vcnt = 0, scnt = 0, exp_sync = 0;

    bit          m_active = 0;
    logic [31:0] m_crc = 32'hFFFF_FFFF;
    int          m_len = 0;
    bit ovr_crc_en = 0, ovr_len_en = 0, ovr_ok_en = 0;
    logic [31:0] ovr_crc;
    int          ovr_len;
    logic        ovr_ok;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Bit-serial reference: one LFSR step per wire bit, LSB of each byte first.
    function automatic logic [31:0] ref_fold(logic [31:0] c_in, logic [63:0] d, logic [7:0] k);
        logic [31:0] c;
        logic fb;
        c = c_in;
        for (int i = 0; i < 8; i++)
            if (k[i])
                for (int b = 0; b < 8; b++) begin
                    fb = c[0] ^ d[8*i + b];
                    c  = c >> 1;
                    if (fb) c = c ^ 32'hEDB8_8320;
                end
        return c;
    endfunction

    function automatic void model(logic s, logic e, logic [63:0] d, logic [7:0] k);
        logic [7:0] ke;
        exp_t x;
        ke = e ? k : 8'hFF;
        if (!s && !m_active) begin
            exp_sync++;
            return;
        end
        if (s) begin
            if (m_active) exp_sync++;
            m_crc = 32'hFFFF_FFFF;
            m_len = 0;
        end
        m_crc = ref_fold(m_crc, d, ke);
        for (int i = 0; i < 8; i++) m_len += int'(ke[i]);
        if (m_len > 65535) m_len = 65535;
        m_active = !e;
        if (e) begin
            x.crc = ovr_crc_en ? ovr_crc : ~m_crc;
            x.len = ovr_len_en ? ovr_len[15:0] : m_len[15:0];
            x.ok  = ovr_ok_en ? ovr_ok : (m_crc == 32'hDEBB_20E3);
            sb.push_back(x);
            ovr_crc_en = 0;
            ovr_len_en = 0;
            ovr_ok_en  = 0;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (crc_valid === 1'b1) begin
            vcnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_crc_valid: got 1 expected 0 (crc_out %h)", crc_out);
            end else begin
                e = sb.pop_front();
                chk("crc_out", crc_out, e.crc);
                chk("frame_len", {16'd0, frame_len}, {16'd0, e.len});
                chk("crc_ok", {31'd0, crc_ok}, {31'd0, e.ok});
            end
        end
        if (sync_err === 1'b1) scnt++;
    end

    task automatic beat(input logic s, input logic e, input logic [63:0] d, input logic [7:0] k);
        v = 1; sof = s; eof = e; data = d; keep = k;
        model(s, e, d, k);
        @(posedge clk); #1;
        v = 0; sof = 0; eof = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_const(input logic [31:0] c, input int l, input logic ok);
        ovr_crc_en = 1; ovr_crc = c;
        ovr_len_en = 1; ovr_len = l;
        ovr_ok_en  = 1; ovr_ok  = ok;
    endtask

    localparam logic [63:0] B1_8 = 64'h3837_3635_3433_3231;

    initial begin
        vec_t tbl[6];
        int s0, v0, nb, kn;
        logic [63:0] rd;
        logic [7:0] seq9 [9];

        tbl[0] = '{B1_8,                  8'hFF, 8, 0, 32'h0};
        tbl[1] = '{64'hDEAD_BEEF_0123_4567, 8'h0F, 4, 0, 32'h0};
        tbl[2] = '{64'h0000_0000_0000_00A5, 8'h01, 1, 0, 32'h0};
        tbl[3] = '{64'h1122_3344_5566_7788, 8'h00, 0, 1, 32'h0};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8, 0, 32'h0};
        tbl[5] = '{64'h0102_0304_0506_0708, 8'h07, 3, 0, 32'h0};
        seq9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        rst = 1; v = 0; sof = 0; eof = 0; data = '0; keep = '0;
        v1 = 0; sof1 = 0; eof1 = 0; d1 = '0; k1 = '0;
        gap(3);
        chk("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
        chk("rst_crc_out", crc_out, 32'd0);
        chk("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
        chk("rst_frame_len", {16'd0, frame_len}, 32'd0);
        chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
        rst = 0;
        gap(1);

        // One byte per beat: the IEEE check value.
        for (int i = 0; i < 9; i++) begin
            v1 = 1; sof1 = (i == 0); eof1 = (i == 8); d1 = seq9[i]; k1 = 1'b1;
            @(posedge clk); #1;
        end
        v1 = 0; sof1 = 0; eof1 = 0;
        @(negedge clk);
        chk("db1_crc_valid", {31'd0, crc_valid1}, 32'd1);
        chk("db1_crc_out", crc_out1, 32'hCBF4_3926);
        chk("db1_frame_len", {16'd0, frame_len1}, 32'd9);
        chk("db1_crc_ok", {31'd0, crc_ok1}, 32'd0);
        gap(1);

        // 9 bytes over two beats with a 3-cycle gap; keep ignored on the first beat.
        v0 = vcnt;
        beat(1, 0, B1_8, 8'h00);
        gap(3);
        expect_const(32'hCBF4_3926, 9, 0);
        beat(0, 1, 64'h39, 8'h01);
        gap(2);
        chk("gap_valid_pulses", vcnt - v0, 1);

        // Frame with its FCS appended, then the same frame with one bit flipped.
        beat(1, 0, B1_8, 8'hFF);
        expect_const(32'h2144_DF1C, 13, 1);
        beat(0, 1, 64'h0000_00CB_F439_2639, 8'h1F);
        beat(1, 0, B1_8 ^ 64'h0000_0001_0000_0000, 8'hFF);
        ovr_len_en = 1; ovr_len = 13; ovr_ok_en = 1; ovr_ok = 0;
        beat(0, 1, 64'h0000_00CB_F439_2639, 8'h1F);
        gap(2);

        // Back-to-back single-beat frames from the table.
        for (int i = 0; i < 6; i++) begin
            ovr_len_en = 1; ovr_len = tbl[i].exp_len;
            if (tbl[i].crc_known) begin
                ovr_crc_en = 1; ovr_crc = tbl[i].exp_crc;
            end
            beat(1, 1, tbl[i].data, tbl[i].keep);
        end
        gap(2);

        // sof inside a frame aborts it.
        s0 = scnt; v0 = vcnt;
        beat(1, 0, 64'hAAAA_5555_AAAA_5555, 8'hFF);
        beat(0, 0, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        ovr_len_en = 1; ovr_len = 8;
        beat(1, 1, B1_8, 8'hFF);
        gap(2);
        chk("abort_sync_pulses", scnt - s0, 1);
        chk("abort_valid_pulses", vcnt - v0, 1);

        // Stray beat while idle, then a clean frame.
        s0 = scnt;
        beat(0, 1, 64'hFFFF_0000_FFFF_0000, 8'hFF);
        gap(2);
        chk("idle_sync_pulses", scnt - s0, 1);
        expect_const(32'hCBF4_3926, 9, 0);
        beat(1, 0, B1_8, 8'hFF);
        beat(0, 1, 64'h39, 8'h01);
        gap(2);

        // Reset mid-frame; the beat coinciding with reset is discarded.
        s0 = scnt; v0 = vcnt;
        beat(1, 0, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF);
        rst = 1; v = 1; sof = 1; eof = 1; data = B1_8; keep = 8'hFF;
        @(posedge clk); #1;
        rst = 0; v = 0; sof = 0; eof = 0;
        m_active = 0;
        chk("mid_rst_crc_out", crc_out, 32'd0);
        chk("mid_rst_frame_len", {16'd0, frame_len}, 32'd0);
        chk("mid_rst_crc_ok", {31'd0, crc_ok}, 32'd0);
        gap(3);
        chk("mid_rst_sync_pulses", scnt - s0, 0);
        chk("mid_rst_valid_pulses", vcnt - v0, 0);
        expect_const(32'hCBF4_3926, 9, 0);
        beat(1, 0, B1_8, 8'hFF);
        beat(0, 1, 64'h39, 8'h01);
        gap(2);

        // Long frame: byte count saturates.
        for (int i = 0; i < 8200; i++) begin
            if (i == 8199) begin
                ovr_len_en = 1; ovr_len = 65535;
            end
            beat(i == 0, i == 8199, {$urandom, $urandom}, 8'hFF);
        end
        gap(2);

        // Random frames with random tail keep and gaps.
        for (int f = 0; f < 100; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                rd = {$urandom, $urandom};
                kn = $urandom_range(0, 8);
                if (b == nb - 1)
                    beat(b == 0, 1, rd, 8'((16'h1 << kn) - 16'h1));
                else
                    beat(b == 0, 0, rd, 8'($urandom));
                gap($urandom_range(0, 2));
            end
        end
        gap(4);

        chk("scoreboard_empty", sb.size(), 0);
        chk("sync_err_total", scnt, exp_sync);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc32_stream_engine.md
# crc32_stream_engine

Parametrised Ethernet CRC-32 engine for the receive and transmit datapaths. It processes DATA_BYTES bytes per clock with per-beat valid and last-beat byte mask, and delimits frames with start/end markers. At end of frame it reports the finished FCS, a residue-based pass/fail check and the frame byte count. It replaces the byte-serial CRC calculator on the wider 10G datapaths and keeps bit-exact IEEE 802.3 behaviour at DATA_BYTES=1.

## Interface
- DATA_BYTES, 8, bytes per beat; legal values 1, 2, 4, 8.
- LEN_W, 16, width of the frame byte counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat qualifier; all other in_* are ignored when low.
- in_sof  in  1  first beat of a frame.
- in_eof  in  1  last beat of a frame.
- in_data  in  8*DATA_BYTES  frame bytes; byte 0 = in_data[7:0] is first on the wire; bit 0 of each byte is first.
- in_keep  in  DATA_BYTES  byte enables; honoured only on eof beats, treated as all-ones otherwise.
- crc_valid  out  1  one-cycle result strobe.
- crc_out  out  32  complemented FCS; crc_out[7:0] is the first FCS byte transmitted.
- crc_ok  out  1  residue check passed (frame included its FCS).
- frame_len  out  LEN_W  bytes accepted in the frame, saturating.
- sync_err  out  1  one-cycle protocol-error strobe.

## Operation
- Polynomial 0x04C11DB7, reflected (LSB-first) form 0xEDB88320. Running register initialises to 0xFFFFFFFF. crc_out = ~register.
- Per beat, bytes 0..DATA_BYTES-1 are folded in order, and only enabled bytes update the register. Masked bytes leave the register unchanged. This is implemented as a DATA_BYTES-deep unrolled byte update with per-stage bypass.
- in_keep on an eof beat must be contiguous from bit 0. A non-contiguous mask is processed as given and is unverified behaviour. A keep of all-zero on an eof beat is legal: the frame ends with no extra bytes.
- State machine:
  - IDLE: on a valid beat with in_sof, the register seeds from 0xFFFFFFFF (not the stale value), the beat is folded, and the block moves to ACTIVE. If the same beat also has in_eof, the block stays in IDLE and emits a result.
  - IDLE: a valid beat without in_sof is dropped and sync_err pulses.
  - ACTIVE: a valid beat without in_sof is folded. If it also has in_eof, a result is emitted and the block returns to IDLE.
  - ACTIVE: a valid beat with in_sof pulses sync_err. The partial frame is discarded with no crc_valid, and the beat is treated as a fresh sof (same rules as IDLE).
- crc_ok = 1 when the final register equals the residue 0xDEBB20E3 (equivalently, ~register == 0x2144DF1C).
- frame_len counts enabled bytes from sof through eof inclusive and saturates at 2^LEN_W-1.
- in_valid low: register, counter and state hold. Gaps of any length are allowed between beats.

## Timing
- Result latency is 1 cycle. An eof beat accepted at cycle N gives crc_valid=1 at N+1, with crc_out, crc_ok and frame_len valid only in that cycle.
- crc_out, crc_ok and frame_len hold their last values when crc_valid=0.
- Back-to-back frames: sof may arrive at N+1 with no bubble. Throughput is one beat per clock.
- sync_err is registered and asserts the cycle after the offending beat.
- Reset values: crc_valid=0, crc_out=0, crc_ok=0, frame_len=0, sync_err=0. Internal register is 0xFFFFFFFF and state is IDLE.
- rst mid-frame discards the frame. No crc_valid or sync_err follows, and the next sof starts clean.
- rst has priority over a simultaneous beat; that beat is discarded.

## Test plan
- DATA_BYTES=1, ASCII "123456789" (bytes 0x31..0x39), sof on first byte, eof on last -> at eof+1: crc_valid=1, crc_out=0xCBF43926, frame_len=9, crc_ok=0.
- DATA_BYTES=8, same 9 bytes as two beats (keep ignored on beat 1, keep=0x01 on beat 2), with a 3-cycle in_valid gap between them -> crc_out=0xCBF43926, frame_len=9, single crc_valid pulse.
- DATA_BYTES=8, "123456789" followed by FCS bytes 0x26 0x39 0xF4 0xCB (13 bytes; last beat keep=0x1F) -> crc_ok=1, frame_len=13. Repeat with bit 0 of byte 4 flipped -> crc_ok=0.
- Frame A with sof and two beats, then sof of frame B (single beat sof+eof, keep=0xFF, "123456789" truncated to 8 bytes) -> sync_err pulses once, no crc_valid for A, frame B crc_valid with frame_len=8 and the CRC from the golden model.
- Back-to-back single-beat frames on consecutive cycles, 100 random frames with random keep and gaps, compared against a byte-serial golden model -> every crc_out, frame_len and crc_ok matches, one crc_valid per frame.
- Assert rst for one cycle mid-frame, then send "123456789" -> all outputs 0 after reset, no stray strobes, then crc_out=0xCBF43926. Separately, a valid beat without sof in IDLE -> sync_err pulses once and the register is unaffected.
